// File: rtl/io_bus_bridge.sv
// ============================================================================
// io_bus_bridge : MEM-stage bridge from the core IO bus to DRAM and board MMIO
// Rev 1.0
// ============================================================================
`default_nettype none

module io_bus_bridge #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          DRAM_AW    = 14,
  parameter logic [19:0] SCAN_DIV   = 20'd50000,
  parameter logic [31:0] TIMER_DIV0 = 32'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [3:0]         mem_ctrl_i,
  input  logic [DATA_W-1:0]  mem_wd_i,
  input  logic               mem_we_i,
  output logic [DATA_W-1:0]  mem_rd_o,
  output logic [DRAM_AW-1:0] dram_addr_o,
  output logic [DATA_W-1:0]  dram_wdata_o,
  output logic [3:0]         dram_be_o,
  output logic               dram_we_o,
  input  logic [DATA_W-1:0]  dram_rdata_i,
  input  logic [23:0]        sw_in_i,
  output logic [23:0]        led_out_o,
  output logic [7:0]         seg_en_o,
  output logic [7:0]         seg_dig_o
);

  localparam logic [9:0] c_off_seg   = 10'h000;
  localparam logic [9:0] c_off_timer = 10'h008;
  localparam logic [9:0] c_off_tdiv  = 10'h009;
  localparam logic [9:0] c_off_led   = 10'h018;
  localparam logic [9:0] c_off_sw    = 10'h01C;

  logic [23:0] led_q;
  logic [31:0] seg_q;
  logic [31:0] timer_q, timer_d;
  logic [31:0] tdiv_q;
  logic [31:0] presc_q, presc_d;
  logic [19:0] scan_q, scan_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] sw_meta_q, sw_sync_q;

  logic        w_we, w_mmio, w_aligned, w_uns;
  logic [1:0]  w_size, w_off;
  logic [9:0]  w_reg;
  logic        w_wr_seg, w_wr_timer, w_wr_tdiv, w_wr_led, w_tick;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_mmio_rd;
  logic [3:0]  w_nibble;

  // ctrl[0] and the strobe are the same signal from the core; both must agree to store
  assign w_we      = mem_we_i & mem_ctrl_i[0];
  assign w_uns     = mem_ctrl_i[3];
  assign w_size    = mem_ctrl_i[2:1];
  assign w_off     = mem_addr_i[1:0];
  assign w_reg     = mem_addr_i[11:2];
  assign w_mmio    = &mem_addr_i[ADDR_W-1:12];
  assign w_aligned = (w_size == 2'b00) ||
                     (w_size == 2'b01 && !w_off[0]) ||
                     (w_size[1] && w_off == 2'b00);

  assign dram_addr_o = mem_addr_i[DRAM_AW+1:2];
  assign dram_we_o   = w_we & ~w_mmio & w_aligned;

  always_comb begin
    dram_be_o    = 4'b1111;
    dram_wdata_o = mem_wd_i;
    case (w_size)
      2'b00: begin
        dram_be_o    = 4'b0001 << w_off;
        dram_wdata_o = {4{mem_wd_i[7:0]}};
      end
      2'b01: begin
        dram_be_o    = w_off[1] ? 4'b1100 : 4'b0011;
        dram_wdata_o = {2{mem_wd_i[15:0]}};
      end
      default: ;
    endcase
    if (!w_aligned) dram_be_o = 4'b0000;
  end

  always_comb begin
    case (w_off)
      2'd0:    w_byte = dram_rdata_i[7:0];
      2'd1:    w_byte = dram_rdata_i[15:8];
      2'd2:    w_byte = dram_rdata_i[23:16];
      default: w_byte = dram_rdata_i[31:24];
    endcase
    w_half = w_off[1] ? dram_rdata_i[31:16] : dram_rdata_i[15:0];
    case (w_size)
      2'b00:   w_load = {{24{~w_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~w_uns & w_half[15]}}, w_half};
      default: w_load = dram_rdata_i;
    endcase
    if (!w_aligned) w_load = 32'd0;
  end

  always_comb begin
    w_mmio_rd = 32'd0;
    case (w_reg)
      c_off_seg:   w_mmio_rd = seg_q;
      c_off_timer: w_mmio_rd = timer_q;
      c_off_tdiv:  w_mmio_rd = tdiv_q;
      c_off_led:   w_mmio_rd = {8'd0, led_q};
      c_off_sw:    w_mmio_rd = {8'd0, sw_sync_q};
      default:     w_mmio_rd = 32'd0;
    endcase
  end

  assign mem_rd_o = w_mmio ? w_mmio_rd : w_load;

  assign w_wr_seg   = w_we & w_mmio & (w_reg == c_off_seg);
  assign w_wr_timer = w_we & w_mmio & (w_reg == c_off_timer);
  assign w_wr_tdiv  = w_we & w_mmio & (w_reg == c_off_tdiv);
  assign w_wr_led   = w_we & w_mmio & (w_reg == c_off_led);
  assign w_tick     = (presc_q == tdiv_q);

  // A CPU write to TIMER overrides a coincident tick
  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q + 32'd1;
    if (w_tick) begin
      timer_d = timer_q + 32'd1;
      presc_d = 32'd0;
    end
    if (w_wr_timer) begin
      timer_d = mem_wd_i;
      presc_d = 32'd0;
    end
    if (w_wr_tdiv) presc_d = 32'd0;
  end

  always_comb begin
    scan_d = scan_q + 20'd1;
    idx_d  = idx_q;
    if (scan_q == SCAN_DIV - 20'd1) begin
      scan_d = 20'd0;
      idx_d  = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 24'd0;
      seg_q     <= 32'd0;
      timer_q   <= 32'd0;
      tdiv_q    <= TIMER_DIV0;
      presc_q   <= 32'd0;
      scan_q    <= 20'd0;
      idx_q     <= 3'd0;
      sw_meta_q <= 24'd0;
      sw_sync_q <= 24'd0;
    end else begin
      if (w_wr_led) led_q  <= mem_wd_i[23:0];
      if (w_wr_seg) seg_q  <= mem_wd_i;
      if (w_wr_tdiv) tdiv_q <= mem_wd_i;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      sw_meta_q <= sw_in_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign w_nibble  = seg_q[{idx_q, 2'b00} +: 4];
  assign led_out_o = led_q;
  assign seg_en_o  = ~(8'b0000_0001 << idx_q);

  always_comb begin
    case (w_nibble)
      4'h0: seg_dig_o = 8'hC0;
      4'h1: seg_dig_o = 8'hF9;
      4'h2: seg_dig_o = 8'hA4;
      4'h3: seg_dig_o = 8'hB0;
      4'h4: seg_dig_o = 8'h99;
      4'h5: seg_dig_o = 8'h92;
      4'h6: seg_dig_o = 8'h82;
      4'h7: seg_dig_o = 8'hF8;
      4'h8: seg_dig_o = 8'h80;
      4'h9: seg_dig_o = 8'h90;
      4'hA: seg_dig_o = 8'h88;
      4'hB: seg_dig_o = 8'h83;
      4'hC: seg_dig_o = 8'hC6;
      4'hD: seg_dig_o = 8'hA1;
      4'hE: seg_dig_o = 8'h86;
      default: seg_dig_o = 8'h8E;
    endcase
  end

endmodule

`default_nettype wire
